bsg_credit_return_fifo: RTL and testbench

Receive-side buffer that pairs with the sender's flow/credit counter. It accepts enqueues only when the sender holds a credit, stores them in an els_p-deep FIFO, and presents them to the consumer through a valid/yumi interface. For each dequeued element it returns a one-cycle credit pulse, which drives the sender counter's up/yumi input. It also reports its own occupancy.

---
 rtl/bsg_credit_return_fifo.sv | 76 +++++++
 tb/tb_bsg_credit_return_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_credit_return_fifo.sv
// Receive-side credit FIFO: buffers sender enqueues and returns one credit pulse per dequeue.
// Optional sticky illegal-handshake flag error_o is enabled by defining BSG_CREDIT_RETURN_FIFO_ERR_EN.
module bsg_credit_return_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 256
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic                       credit_o,
    output logic [$clog2(els_p+1)-1:0] count_o
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
    ,
    output logic                       error_o
`endif
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [cnt_w-1:0]   occ;
    logic               enq;
    logic               deq;
    logic               credit_p1;

    assign ready_o  = (occ != cnt_w'(els_p));
    assign v_o      = (occ != '0);
    assign enq      = v_i & ready_o;
    assign deq      = yumi_i & v_o;
    assign data_o   = mem[rptr];
    assign count_o  = occ;
    assign credit_o = credit_p1;

    // stage p1: pointers, occupancy and the lagged credit pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            credit_p1 <= 1'b0;
        end else begin
            if (enq) wptr <= wptr + ptr_w'(1);
            if (deq) rptr <= rptr + ptr_w'(1);
            occ       <= occ + cnt_w'(enq) - cnt_w'(deq);
            credit_p1 <= deq;
        end
    end

    // Storage is never reset; v_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
    logic err_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_p1 <= 1'b0;
        end else if ((v_i & ~ready_o) | (yumi_i & ~v_o)) begin
            err_p1 <= 1'b1;
        end
    end

    assign error_o = err_p1;
`endif

endmodule

// File: tb/tb_bsg_credit_return_fifo.sv
// Directed bench for bsg_credit_return_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_bsg_credit_return_fifo;

    localparam int W   = 32;
    localparam int ELS = 256;

    logic          clk;
    logic          reset_i;
    logic          v_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic          credit_o;
    logic [8:0]    count_o;
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
    logic          error_o;
`endif

    bsg_credit_return_fifo #(.width_p(W), .els_p(ELS)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i),
        .credit_o(credit_o),
        .count_o (count_o)
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
        ,
        .error_o (error_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, expected credit, error flag, and sender credit counter.
    logic [W-1:0] mq[$];
    logic         m_credit;
    logic         m_err;
    int           sender;

    always @(posedge clk) begin
        logic m_enq, m_deq;
        if (reset_i) begin
            mq.delete();
            m_credit = 1'b0;
            m_err    = 1'b0;
            sender   = ELS;
        end else begin
            m_enq = v_i && (mq.size() < ELS);
            m_deq = yumi_i && (mq.size() > 0);
            if ((v_i && mq.size() == ELS) || (yumi_i && mq.size() == 0)) m_err = 1'b1;
            sender = sender - int'(m_enq) + int'(credit_o);
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back(data_i);
            m_credit = m_deq;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m.v_o", 64'(v_o), 64'(mq.size() != 0));
        check("m.ready_o", 64'(ready_o), 64'(mq.size() != ELS));
        check("m.count_o", 64'(count_o), 64'(mq.size()));
        check("m.credit_o", 64'(credit_o), 64'(m_credit));
        if (mq.size() != 0) check("m.data_o", 64'(data_o), 64'(mq[0]));
        check("m.invariant", 64'(sender + int'(count_o) + int'(credit_o)), 64'(ELS));
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
        check("m.error_o", 64'(error_o), 64'(m_err));
`endif
    endtask

    // Apply inputs for one cycle, then sample 2 time units after the edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic y, input logic r);
        v_i     = v;
        data_i  = d;
        yumi_i  = y;
        reset_i = r;
        @(posedge clk);
        #2;
        compare_model();
    endtask

    initial begin
        v_i = 0; data_i = '0; yumi_i = 0; reset_i = 1;
        @(posedge clk);
        #2;
        cyc(0, 0, 0, 1);

        cyc(0, 0, 0, 0);
        check("rst.v_o", 64'(v_o), 64'd0);
        check("rst.ready_o", 64'(ready_o), 64'd1);
        check("rst.count_o", 64'(count_o), 64'd0);
        check("rst.credit_o", 64'(credit_o), 64'd0);
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
        check("rst.error_o", 64'(error_o), 64'd0);
`endif

        // single enqueue then dequeue
        cyc(1, 32'hA5A5A5A5, 0, 0);
        check("single.v_o", 64'(v_o), 64'd1);
        check("single.data_o", 64'(data_o), 64'hA5A5A5A5);
        check("single.count_o", 64'(count_o), 64'd1);
        cyc(0, 0, 1, 0);
        check("single.credit_o", 64'(credit_o), 64'd1);
        check("single.v_o_after", 64'(v_o), 64'd0);
        check("single.count_after", 64'(count_o), 64'd0);
        cyc(0, 0, 0, 0);
        check("single.credit_end", 64'(credit_o), 64'd0);

        // fill 0..255, then drain in order
        for (int i = 0; i < ELS; i++) cyc(1, W'(i), 0, 0);
        check("fill.ready_o", 64'(ready_o), 64'd0);
        check("fill.count_o", 64'(count_o), 64'd256);
        for (int i = 0; i < ELS; i++) begin
            check("drain.data_o", 64'(data_o), 64'(i));
            cyc(0, 0, 1, 0);
            check("drain.credit_o", 64'(credit_o), 64'd1);
        end
        check("drain.count_o", 64'(count_o), 64'd0);
        cyc(0, 0, 0, 0);
        check("drain.credit_end", 64'(credit_o), 64'd0);

        // pointer wrap with steady occupancy of 200
        for (int i = 0; i < 200; i++) cyc(1, W'(1000 + i), 0, 0);
        for (int k = 0; k < 300; k++) begin
            check("wrap.data_o", 64'(data_o), (k < 200) ? 64'(1000 + k) : 64'(2000 + k - 200));
            cyc(1, W'(2000 + k), 1, 0);
            check("wrap.count_o", 64'(count_o), 64'd200);
            check("wrap.credit_o", 64'(credit_o), 64'd1);
        end
        for (int i = 0; i < 200; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("wrap.empty", 64'(count_o), 64'd0);

        // full with both v_i and yumi_i high: dequeue only
        for (int i = 0; i < ELS; i++) cyc(1, W'(i), 0, 0);
        cyc(1, 32'hDEAD, 1, 0);
        check("fullboth.count_o", 64'(count_o), 64'd255);
        check("fullboth.credit_o", 64'(credit_o), 64'd1);
        check("fullboth.data_o", 64'(data_o), 64'd1);
        cyc(1, 32'hBEEF, 0, 0);
        check("fullboth.count_back", 64'(count_o), 64'd256);
        check("fullboth.credit_end", 64'(credit_o), 64'd0);

        // v_i while full is dropped
        cyc(1, 32'h1234, 0, 0);
        check("illegal_v.count_o", 64'(count_o), 64'd256);
        check("illegal_v.data_o", 64'(data_o), 64'd1);
        check("illegal_v.credit_o", 64'(credit_o), 64'd0);
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
        check("illegal_v.error_o", 64'(error_o), 64'd1);
`endif
        for (int i = 0; i < ELS; i++) begin
            if (i == ELS - 1) check("illegal_v.last", 64'(data_o), 64'hBEEF);
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0);

        // yumi_i while empty is ignored
        cyc(0, 0, 1, 0);
        check("illegal_y.count_o", 64'(count_o), 64'd0);
        check("illegal_y.credit_o", 64'(credit_o), 64'd0);
        check("illegal_y.v_o", 64'(v_o), 64'd0);

        // reset mid-fill, with a dequeue requested in the reset cycle
        for (int i = 0; i < 57; i++) cyc(1, W'(i + 7), 0, 0);
        check("midrst.count_pre", 64'(count_o), 64'd57);
        cyc(0, 0, 1, 1);
        check("midrst.count_o", 64'(count_o), 64'd0);
        check("midrst.credit_o", 64'(credit_o), 64'd0);
        check("midrst.v_o", 64'(v_o), 64'd0);
        check("midrst.ready_o", 64'(ready_o), 64'd1);
`ifdef BSG_CREDIT_RETURN_FIFO_ERR_EN
        check("midrst.error_o", 64'(error_o), 64'd0);
`endif
        cyc(0, 0, 0, 0);
        check("midrst.idle_count", 64'(count_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
